// File: rtl/io_wb_pkg.sv
// Shared types and helpers for the Z80 IO to Wishbone bridge.
// Used by io_wb_bridge and its interface.
package io_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] IDLE_DATA = 8'hFF;

  function automatic int sel_bits(input int n);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) b = i + 1;
    return b;
  endfunction

endpackage

// File: rtl/io_wb_bridge_if.sv
// Wishbone side of the Z80 IO bridge: one-hot strobes,
// shared write enable/address/data, per-device read data and ack.
interface io_wb_bridge_if #(
  parameter int NUM_DEV = 16
) ();

  logic [NUM_DEV-1:0]   stb_o;
  logic                 we_o;
  logic [7:0]           adr_o;
  logic [7:0]           dat_o;
  logic [8*NUM_DEV-1:0] dat_i;
  logic [NUM_DEV-1:0]   ack_i;

  modport master (
    output stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/io_strobe_sync.sv
// Two-flop synchroniser for the Z80 IO strobes plus
// rising-edge detect of the combined read/write activity.
module io_strobe_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_niorq,
  input  logic i_nrd,
  input  logic i_nwr,
  output logic o_io_wr,
  output logic o_act,
  output logic o_start
);

  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic       r_act_d;
  logic       w_io_rd;
  logic       w_io_wr;
  logic       w_act;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 3'b111;
      r_s2    <= 3'b111;
      r_act_d <= 1'b0;
    end else begin
      r_s1    <= {i_niorq, i_nrd, i_nwr};
      r_s2    <= r_s1;
      r_act_d <= w_act;
    end
  end

  assign w_io_rd = !r_s2[2] && !r_s2[1];
  assign w_io_wr = !r_s2[2] && !r_s2[0];
  assign w_act   = w_io_rd || w_io_wr;

  assign o_io_wr = w_io_wr;
  assign o_act   = w_act;
  assign o_start = w_act && !r_act_d;

endmodule

// File: rtl/io_wb_bridge.sv
// Z80 IO cycle to Wishbone bridge with NUM_DEV one-hot device strobes.
// Define IO_WB_TIMEOUT_EN to enable the ack-timeout abort and err_o.
module io_wb_bridge
  import io_wb_pkg::*;
#(
  parameter int NUM_DEV     = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [7:0]      A_i,
  input  logic [7:0]      D_i,
  output logic [7:0]      D_o,
  input  logic            nrd_i,
  input  logic            nwr_i,
  input  logic            niorq_i,
  output logic            nwait_o,
  io_wb_bridge_if.master  wb,
  output logic            err_o
);

  localparam int SEL_BITS = sel_bits(NUM_DEV);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] STROBE = ST_STROBE;
  localparam logic [1:0] DONE   = ST_DONE;

  logic [1:0]          r_state;
  logic [NUM_DEV-1:0]  r_stb;
  logic                r_we;
  logic [7:0]          r_adr;
  logic [7:0]          r_dat;
  logic [7:0]          r_do;
  logic [SEL_BITS-1:0] r_sel;

  logic                w_io_wr;
  logic                w_act;
  logic                w_start;
  logic [SEL_BITS-1:0] w_sel;
  logic                w_ack;
  logic [7:0]          w_rdat;
  logic                w_tmo;

  io_strobe_sync u_sync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_niorq (niorq_i),
    .i_nrd   (nrd_i),
    .i_nwr   (nwr_i),
    .o_io_wr (w_io_wr),
    .o_act   (w_act),
    .o_start (w_start)
  );

  assign w_sel  = A_i[7 -: SEL_BITS];
  assign w_ack  = wb.ack_i[r_sel];
  assign w_rdat = wb.dat_i[{r_sel, 3'b000} +: 8];

`ifdef IO_WB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  assign w_tmo = (r_cnt == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE)
        r_cnt <= 8'd0;
      else if (r_state == STROBE)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == STROBE && !w_ack && w_act && w_tmo)
        r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_tmo = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_stb   <= '0;
      r_we    <= 1'b0;
      r_adr   <= IDLE_DATA;
      r_dat   <= IDLE_DATA;
      r_do    <= IDLE_DATA;
      r_sel   <= '0;
    end else begin
      unique case (1'b1)
        (r_state == IDLE): begin
          r_do <= IDLE_DATA;
          if (w_start) begin
            r_adr   <= A_i;
            r_dat   <= D_i;
            r_we    <= w_io_wr;
            r_sel   <= w_sel;
            r_stb   <= NUM_DEV'(1) << w_sel;
            r_state <= STROBE;
          end
        end
        (r_state == STROBE): begin
          // ack wins over a cycle end seen in the same clock
          if (w_ack) begin
            r_stb   <= '0;
            r_we    <= 1'b0;
            if (!r_we) r_do <= w_rdat;
            r_state <= DONE;
          end else if (!w_act) begin
            r_stb   <= '0;
            r_we    <= 1'b0;
            r_state <= IDLE;
          end else if (w_tmo) begin
            r_stb   <= '0;
            r_we    <= 1'b0;
            r_do    <= IDLE_DATA;
            r_state <= DONE;
          end
        end
        (r_state == DONE): begin
          if (!w_act) begin
            r_do    <= IDLE_DATA;
            r_state <= IDLE;
          end
        end
        default: begin
          r_stb   <= '0;
          r_we    <= 1'b0;
          r_do    <= IDLE_DATA;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wb.stb_o = r_stb;
  assign wb.we_o  = r_we;
  assign wb.adr_o = r_adr;
  assign wb.dat_o = r_dat;
  assign D_o      = r_do;

  // CPU is released once the transfer is done, even while strobes stay low
  assign nwait_o = !(!niorq_i && (!nrd_i || !nwr_i) && r_state != DONE);

endmodule

// File: tb/tb_io_wb_bridge.sv
// Directed bench for io_wb_bridge: a 16-device and a 4-device
// instance share the Z80 side; each has its own Wishbone side.
module tb_io_wb_bridge;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] d;
  logic       nrd;
  logic       nwr;
  logic       niorq;

  logic [7:0] do16;
  logic [7:0] do4;
  logic       nwait16;
  logic       nwait4;
  logic       err16;
  logic       err4;
  logic       exp_err;

  int checks;
  int errors;

  io_wb_bridge_if #(.NUM_DEV(16)) wb16 ();
  io_wb_bridge_if #(.NUM_DEV(4))  wb4 ();

  io_wb_bridge #(.NUM_DEV(16), .ACK_TIMEOUT(15)) dut16 (
    .clk_i   (clk),
    .rst_i   (rst),
    .A_i     (a),
    .D_i     (d),
    .D_o     (do16),
    .nrd_i   (nrd),
    .nwr_i   (nwr),
    .niorq_i (niorq),
    .nwait_o (nwait16),
    .wb      (wb16),
    .err_o   (err16)
  );

  io_wb_bridge #(.NUM_DEV(4), .ACK_TIMEOUT(15)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .A_i     (a),
    .D_i     (d),
    .D_o     (do4),
    .nrd_i   (nrd),
    .nwr_i   (nwr),
    .niorq_i (niorq),
    .nwait_o (nwait4),
    .wb      (wb4),
    .err_o   (err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef IO_WB_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst   = 1'b1;
    a     = 8'h00;
    d     = 8'h00;
    nrd   = 1'b1;
    nwr   = 1'b1;
    niorq = 1'b1;
    wb16.ack_i = '0;
    wb16.dat_i = {16{8'h5A}};
    wb4.ack_i  = '0;
    wb4.dat_i  = 32'h00C3_B2A1;
    tick(2);
    rst = 1'b0;
    tick(1);

    check("rst_stb", 32'(wb16.stb_o), 32'h0);
    check("rst_we", 32'(wb16.we_o), 32'h0);
    check("rst_adr", 32'(wb16.adr_o), 32'hFF);
    check("rst_dat", 32'(wb16.dat_o), 32'hFF);
    check("rst_do", 32'(do16), 32'hFF);
    check("rst_err", 32'(err16), 32'h0);
    check("rst_nwait", 32'(nwait16), 32'h1);

    // 16-device write to device 3
    a = 8'h3A; d = 8'h55; niorq = 1'b0; nwr = 1'b0;
    #1;
    check("wr_nwait_low", 32'(nwait16), 32'h0);
    tick(2);
    check("wr_stb_latency", 32'(wb16.stb_o), 32'h0);
    tick(1);
    check("wr_stb", 32'(wb16.stb_o), 32'h0008);
    check("wr_we", 32'(wb16.we_o), 32'h1);
    check("wr_adr", 32'(wb16.adr_o), 32'h3A);
    check("wr_dat", 32'(wb16.dat_o), 32'h55);
    wb16.ack_i[3] = 1'b1;
    tick(1);
    wb16.ack_i = '0;
    check("wr_stb_drop", 32'(wb16.stb_o), 32'h0);
    check("wr_we_drop", 32'(wb16.we_o), 32'h0);
    check("wr_nwait_high", 32'(nwait16), 32'h1);
    check("wr_do_kept", 32'(do16), 32'hFF);
    niorq = 1'b1; nwr = 1'b1;
    tick(4);

    // 4-device read from device 3
    wb4.dat_i[31:24] = 8'hA7;
    a = 8'hC1; niorq = 1'b0; nrd = 1'b0;
    tick(3);
    check("rd4_stb", 32'(wb4.stb_o), 32'h8);
    check("rd4_we", 32'(wb4.we_o), 32'h0);
    check("rd16_stb", 32'(wb16.stb_o), 32'h1000);
    tick(2);
    check("rd4_stb_wait", 32'(wb4.stb_o), 32'h8);
    check("rd4_nwait_low", 32'(nwait4), 32'h0);
    wb4.ack_i[3] = 1'b1;
    tick(1);
    wb4.ack_i = '0;
    check("rd4_stb_drop", 32'(wb4.stb_o), 32'h0);
    check("rd4_do", 32'(do4), 32'hA7);
    tick(1);
    check("rd4_do_hold", 32'(do4), 32'hA7);
    niorq = 1'b1; nrd = 1'b1;
    tick(1);
    check("rd4_do_end_sync", 32'(do4), 32'hA7);
    tick(2);
    check("rd4_do_idle", 32'(do4), 32'hFF);
    check("rd16_abort_stb", 32'(wb16.stb_o), 32'h0);
    tick(2);

    // ack from the wrong device is ignored, CPU abandons the cycle
    a = 8'h25; d = 8'h11; niorq = 1'b0; nwr = 1'b0;
    tick(3);
    check("ign_stb", 32'(wb16.stb_o), 32'h0004);
    wb16.ack_i[5] = 1'b1;
    tick(2);
    check("ign_stb_hold", 32'(wb16.stb_o), 32'h0004);
    niorq = 1'b1; nwr = 1'b1;
    tick(2);
    check("ign_stb_sync", 32'(wb16.stb_o), 32'h0004);
    tick(1);
    wb16.ack_i = '0;
    check("ign_stb_drop", 32'(wb16.stb_o), 32'h0);
    check("ign_we_drop", 32'(wb16.we_o), 32'h0);
    check("ign_err", 32'(err16), 32'h0);
    tick(2);

    // no ack at all: timeout abort when enabled, endless wait otherwise
    a = 8'h40; niorq = 1'b0; nrd = 1'b0;
    tick(3);
    check("tmo_stb", 32'(wb16.stb_o), 32'h0010);
    tick(14);
    check("tmo_stb_14", 32'(wb16.stb_o), 32'h0010);
    tick(1);
    check("tmo_stb_15", 32'(wb16.stb_o), exp_err ? 32'h0 : 32'h0010);
    check("tmo_err", 32'(err16), 32'(exp_err));
    check("tmo_do", 32'(do16), 32'hFF);
    check("tmo_nwait", 32'(nwait16), 32'(exp_err));
    niorq = 1'b1; nrd = 1'b1;
    tick(4);
    check("tmo_idle_stb", 32'(wb16.stb_o), 32'h0);

    // good read after the timeout; err stays sticky
    wb16.dat_i[8*6 +: 8] = 8'h3C;
    a = 8'h6F; niorq = 1'b0; nrd = 1'b0;
    tick(3);
    check("post_stb", 32'(wb16.stb_o), 32'h0040);
    wb16.ack_i[6] = 1'b1;
    tick(1);
    wb16.ack_i = '0;
    check("post_do", 32'(do16), 32'h3C);
    check("post_err_sticky", 32'(err16), 32'(exp_err));
    niorq = 1'b1; nrd = 1'b1;
    tick(4);

    // reset in the middle of a strobe
    a = 8'h3A; d = 8'h55; niorq = 1'b0; nwr = 1'b0;
    tick(3);
    check("mid_stb", 32'(wb16.stb_o), 32'h0008);
    rst = 1'b1;
    tick(1);
    check("mid_rst_stb", 32'(wb16.stb_o), 32'h0);
    check("mid_rst_adr", 32'(wb16.adr_o), 32'hFF);
    check("mid_rst_do", 32'(do16), 32'hFF);
    check("mid_rst_we", 32'(wb16.we_o), 32'h0);
    check("mid_rst_err", 32'(err16), 32'h0);
    check("mid_rst_nwait", 32'(nwait16), 32'h0);
    a = 8'h71; d = 8'h99;
    rst = 1'b0;
    tick(2);
    check("after_rst_latency", 32'(wb16.stb_o), 32'h0);
    tick(1);
    check("after_rst_stb", 32'(wb16.stb_o), 32'h0080);
    check("after_rst_adr", 32'(wb16.adr_o), 32'h71);
    check("after_rst_dat", 32'(wb16.dat_o), 32'h99);
    check("after_rst_we", 32'(wb16.we_o), 32'h1);
    wb16.ack_i[7] = 1'b1;
    tick(1);
    wb16.ack_i = '0;
    check("after_rst_drop", 32'(wb16.stb_o), 32'h0);
    check("after_rst_nwait", 32'(nwait16), 32'h1);
    niorq = 1'b1; nwr = 1'b1;
    tick(4);
    check("final_idle_stb", 32'(wb16.stb_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
